// File: rtl/alu_out_buffer_if.sv
// Handshake bundle between the ALU output buffer and its producer/consumer.
// The buffer takes the slave view; the ALU and result consumer take the master view.
interface alu_out_buffer_if #(parameter int n = 4);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] result;
  logic [3:0]   flags;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_result;
  logic [3:0]   out_flags;
  logic [1:0]   count;

  modport master (
    output in_valid, result, flags, out_ready,
    input  in_ready, out_valid, out_result, out_flags, count
  );

  modport slave (
    input  in_valid, result, flags, out_ready,
    output in_ready, out_valid, out_result, out_flags, count
  );
endinterface

// File: rtl/alu_out_buffer.sv
// 2-entry FIFO holding ALU result + {N,Z,C,V}; push into empty shows on outputs next cycle, full throughput at count 1.
// in_ready drops only when both entries are held; STICKY_FLAGS_EN adds sticky {C,V} accumulation over popped entries.
module alu_out_buffer #(
  parameter int n = 4
) (
  input  logic            clk,
  input  logic            reset,
  alu_out_buffer_if.slave bus
`ifdef STICKY_FLAGS_EN
  ,
  input  logic            sticky_clr,
  output logic [1:0]      sticky_cv
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic         push, pop;
  logic         load_head_in, load_head_tail, load_tail;
  logic [n-1:0] head_result, tail_result;
  logic [3:0]   head_flags, tail_flags;

  assign bus.in_ready   = (state != FULL);
  assign bus.out_valid  = (state != EMPTY);
  assign bus.count      = state;
  assign bus.out_result = head_result;
  assign bus.out_flags  = head_flags;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_head_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            load_tail = 1'b1;
            state_nxt = FULL;
          end
          2'b01: state_nxt = EMPTY;
          // Simultaneous push and pop replaces the head in place: one result per cycle.
          2'b11: load_head_in = 1'b1;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          load_head_tail = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_result <= '0;
      head_flags  <= '0;
      tail_result <= '0;
      tail_flags  <= '0;
    end else begin
      if (load_head_in) begin
        head_result <= bus.result;
        head_flags  <= bus.flags;
      end else if (load_head_tail) begin
        head_result <= tail_result;
        head_flags  <= tail_flags;
      end
      if (load_tail) begin
        tail_result <= bus.result;
        tail_flags  <= bus.flags;
      end
    end
  end

`ifdef STICKY_FLAGS_EN
  // Clear takes effect before the popped entry's {C,V} are ORed in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_cv <= 2'b00;
    end else if (pop) begin
      sticky_cv <= (sticky_clr ? 2'b00 : sticky_cv) | head_flags[1:0];
    end else if (sticky_clr) begin
      sticky_cv <= 2'b00;
    end
  end
`endif

endmodule
